// File: rtl/prbs_pkg.sv
// Shared helpers for the PRBS datapath: lane mapping and keep-mask tests.
// Used by serial_parallel_stream and sp_out_stage.
package prbs_pkg;

    localparam int DEFAULT_W = 8;

    // Lane that serial word k lands in for a frame of n lanes.
    function automatic int lane_of(
        input int k,
        input int n,
        input bit msb_first
    );
        return msb_first ? (n - 1 - k) : k;
    endfunction

    // True when lane carries data after fill words have been packed.
    function automatic bit lane_kept(
        input int lane,
        input int fill,
        input int n,
        input bit msb_first
    );
        return msb_first ? (lane >= n - fill) : (lane < fill);
    endfunction

endpackage

// File: rtl/sp_out_stage.sv
// Single-entry valid/ready output register that can reload while draining.
// Optional frame counter enabled by SERIAL_PARALLEL_FRAME_CNT_EN.
module sp_out_stage
    import prbs_pkg::*;
#(
    parameter int N = 4,
    parameter int W = DEFAULT_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic [N*W-1:0] load_data,
    input  logic [N-1:0]   load_keep,
    input  logic           out_ready,
    output logic [N*W-1:0] out_data,
    output logic [N-1:0]   out_keep,
    output logic           out_valid
`ifdef SERIAL_PARALLEL_FRAME_CNT_EN
    ,
    output logic [15:0]    out_frame_cnt
`endif
);

    // A load in the same cycle as a consume replaces the frame, no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_keep  <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            out_data  <= load_data;
            out_keep  <= load_keep;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef SERIAL_PARALLEL_FRAME_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_frame_cnt <= '0;
        end else if (out_valid && out_ready) begin
            out_frame_cnt <= out_frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: rtl/serial_parallel_stream.sv
// Serial-to-parallel packer: N words of W bits into one keep-qualified frame.
// Optional out_frame_cnt port enabled by SERIAL_PARALLEL_FRAME_CNT_EN.
module serial_parallel_stream
    import prbs_pkg::*;
#(
    parameter int N         = 4,
    parameter int W         = DEFAULT_W,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   in_data,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           flush,
    output logic [N*W-1:0] out_data,
    output logic [N-1:0]   out_keep,
    output logic           out_valid,
    input  logic           out_ready
`ifdef SERIAL_PARALLEL_FRAME_CNT_EN
    ,
    output logic [15:0]    out_frame_cnt
`endif
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0]  count;
    logic [N*W-1:0] acc;
    logic [N*W-1:0] merged;
    logic [N-1:0]   load_keep;
    logic           flush_pend;
    logic           flush_req;
    logic           accept;
    logic           last;
    logic           free;
    logic           do_flush;
    logic           load;
    int             fill;

    // Only a frame-completing word can be blocked by a stalled output.
    assign in_ready = !(out_valid && !out_ready && (count == LAST));

    always_comb begin
        accept    = in_valid && in_ready;
        free      = !out_valid || out_ready;
        flush_req = flush || flush_pend;
        last      = accept && (count == LAST);
        fill      = int'(count) + (accept ? 1 : 0);
        do_flush  = flush_req && free && !last && (fill > 0);
        load      = last || do_flush;
        merged    = acc;
        load_keep = '0;
        for (int l = 0; l < N; l++) begin
            if (accept && (lane_of(int'(count), N, MSB_FIRST) == l)) begin
                merged[l*W +: W] = in_data;
            end
            load_keep[l] = lane_kept(l, fill, N, MSB_FIRST);
        end
    end

    // A flush on an empty packer is dropped; otherwise it waits for a free output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= '0;
            acc        <= '0;
            flush_pend <= 1'b0;
        end else begin
            if (load) begin
                count <= '0;
                acc   <= '0;
            end else if (accept) begin
                count <= count + CW'(1);
                acc   <= merged;
            end
            flush_pend <= flush_req && !load && (fill > 0);
        end
    end

    sp_out_stage #(
        .N (N),
        .W (W)
    ) u_out (
        .clk           (clk),
        .rst           (rst),
        .load          (load),
        .load_data     (merged),
        .load_keep     (load_keep),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_keep      (out_keep),
        .out_valid     (out_valid)
`ifdef SERIAL_PARALLEL_FRAME_CNT_EN
        ,
        .out_frame_cnt (out_frame_cnt)
`endif
    );

endmodule

// File: doc/serial_parallel_stream.md
Name: serial_parallel_stream

Overview:
Parametrised, continuously running serial-to-parallel packer for the PRBS datapath. It gathers N words of W bits from a valid/ready input stream into one N*W-bit frame. The frame is presented on a valid/ready output stage with per-lane keep, and the block re-arms for the next frame automatically. It sits between the byte-serial PRBS/pattern source and the wide pattern comparator, and supports configurable lane order and partial-frame flush.

Parameters:
N, 4, words per output frame; legal range N >= 2
W, 8, word width in bits; legal range W >= 1
MSB_FIRST, 0, lane order: 0 = first word lands in lane 0 (LSBs); 1 = first word lands in lane N-1 (MSBs)

Ports:
clk  input  1  clock; all logic on the rising edge
rst  input  1  reset; asynchronous, active-high
in_data  input  W  serial word
in_valid  input  1  in_data is valid
in_ready  output  1  block accepts in_data this cycle
flush  input  1  emit the current partial frame (single-cycle pulse)
out_data  output  N*W  packed frame
out_keep  output  N  per-lane valid mask; bit k covers out_data[W*k +: W]
out_valid  output  1  frame held on out_data/out_keep
out_ready  input  1  downstream consumes the frame

Behaviour:
- Reset (async, active-high): out_data=0, out_keep=0, out_valid=0, fill count=0, accumulator=0. in_ready is high immediately after reset deasserts.
- Structure: accumulator register holds lanes for words 0..N-2; fill counter is $clog2(N) bits, range 0..N-1; output register holds the frame plus out_valid.
- Accept: a word is accepted when in_valid && in_ready.
- Lane mapping: word index k goes to lane k, or to lane N-1-k if MSB_FIRST=1.
- Counter increments on each accepted word. On the word with count==N-1, the accumulator merged with that word loads the output register, out_keep=all ones, out_valid=1, count returns to 0, and the accumulator clears.
- Latency: the last word accepted at cycle t gives out_valid=1 at cycle t+1. Sustained throughput is 1 word/cycle when out_ready is held high.
- Output handshake: out_data/out_keep are stable while out_valid && !out_ready. out_valid clears on out_ready unless a new frame loads in the same cycle, in which case the new frame replaces it with no bubble.
- Backpressure: words 0..N-2 of the next frame are accepted into the accumulator while the output is stalled. in_ready = !(out_valid && !out_ready && count==N-1). So the block stalls only on a frame-completing word.
- Flush with count>0: emits the partial frame. Filled lanes carry data, unfilled lanes are 0, and out_keep marks the filled lanes. count then clears.
  - Flush with count==0 is ignored.
  - Flush is only honoured when the output register is free (!out_valid || out_ready). Otherwise it is held pending internally until honoured.
- Simultaneous accepted word and flush: the word is included first, then the frame is emitted. If that word completes the frame, exactly one full frame is emitted and the flush is consumed.
- Reset mid-frame: the partial frame is discarded with no output.
- Counter wrap: the counter never exceeds N-1. Non-power-of-two N is legal.

Optional Feature:
SERIAL_PARALLEL_FRAME_CNT_EN.
- Defined: adds output port out_frame_cnt [15:0]. It increments by 1 on each out_valid && out_ready handshake, wraps 0xFFFF -> 0x0000, and resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package prbs_pkg: lane-index function (k, N, MSB_FIRST) -> lane; keep-mask constant helper; default W=8.
- One sub-module, sp_out_stage: single-entry valid/ready output register with load-while-draining.
- The accumulator, counter and flush-pending logic stay in the top level.

Test Plan:
1. N=4, W=8, LSB-first, out_ready=1. Feed 0x11,0x22,0x33,0x44 on consecutive cycles -> out_data=0x44332211, out_keep=4'hF, out_valid high exactly one cycle after 0x44.
2. Same with MSB_FIRST=1 -> out_data=0x11223344.
3. out_ready=0, in_valid held with words 0x01..0x08 -> frame 0x04030201 holds; 0x05..0x07 accepted; in_ready low with 0x08 waiting. Raise out_ready -> 0x08070605 follows on the next cycle with no bubble.
4. Feed 0xAA,0xBB then pulse flush -> out_data=0x0000BBAA, out_keep=4'b0011. A flush pulse with count==0 produces no output.
5. Flush coincident with the 4th word 0x44 -> a single frame 0x44332211 with keep 4'hF. Assert rst after 2 words -> outputs 0 asynchronously; the next 4 words form a clean frame.
6. SERIAL_PARALLEL_FRAME_CNT_EN defined: 3 frames consumed -> out_frame_cnt=3; preload near 0xFFFF -> wraps to 0.
